// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-game round controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_GO         = 3'd2,
    ST_HOLDOFF    = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16/14/13/11 of x^16+x^14+x^13+x^11+1, as bit positions 15/13/12/10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int CNT_W = 16;

  // One Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms tick: one-cycle pulse every TICK_DIV clocks, restartable.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == W'(TICK_DIV - 1));

  // Wrap after the tick; a clear restarts the period from zero.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tick_o) cnt_d = '0;
    if (clr_i)  cnt_d = '0;
  end

  // Period counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round sequencer, press arbiter and scorekeeper for the two-player reaction game.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DELAY_BITS   = 11,
  parameter int TIMEOUT_MS   = 3000,
  parameter int HOLDOFF_MS   = 500,
  parameter int WIN_SCORE    = 5,
  parameter int SCORE_W      = 4
) (
  input  logic               cin,
  input  logic               reset,
  input  logic               start,
  input  logic               clear_scores,
  input  logic               p1_sw,
  input  logic               p2_sw,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               armed,
  output logic               go,
  output logic [1:0]         score_evt,
  output logic [1:0]         winner,
  output logic [15:0]        reaction_ms,
  output logic               round_done
);

  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   RAND_MASK = CNT_W'((32'd1 << DELAY_BITS) - 32'd1);
  localparam logic [CNT_W-1:0]   DMIN      = CNT_W'(DELAY_MIN_MS);
  localparam logic [CNT_W-1:0]   HOLD      = CNT_W'(HOLDOFF_MS);

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q;
  logic               p1_prev_q, p2_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // countdown / holdoff ms remaining
  logic [15:0]        react_q, react_d;    // ms elapsed in GO
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         evt_q, evt_d, win_q, win_d;
  logic [15:0]        rms_q, rms_d;
  logic               done_q, done_d;
  logic               tick, tick_clr, p1_e, p2_e;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

  assign p1_e   = p1_sw & ~p1_prev_q;
  assign p2_e   = p2_sw & ~p2_prev_q;
  assign p1_inc = (p1_q >= WIN) ? WIN : p1_q + SCORE_W'(1);
  assign p2_inc = (p2_q >= WIN) ? WIN : p2_q + SCORE_W'(1);

  // Restarting the ms grid on every state change makes countdown, reaction
  // time and holdoff all exact multiples of TICK_DIV from the transition.
  assign tick_clr = (state_d != state_q);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (cin),
    .rst_ni (reset),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Round FSM: next state, counters and score updates; clear_scores overrides all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    react_d = react_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    evt_d   = 2'b00;
    win_d   = win_q;
    rms_d   = rms_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !p1_sw && !p2_sw) begin
          state_d = ST_COUNTDOWN;
          cnt_d   = DMIN + (lfsr_q & RAND_MASK);
        end
      end
      ST_COUNTDOWN: begin
        if (p1_e || p2_e) begin
          if (p1_e && p1_q != '0) begin p1_d = p1_q - SCORE_W'(1); evt_d[0] = 1'b1; end
          if (p2_e && p2_q != '0) begin p2_d = p2_q - SCORE_W'(1); evt_d[1] = 1'b1; end
          state_d = ST_HOLDOFF;
          cnt_d   = HOLD;
          done_d  = 1'b1;
        end else if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_GO;
            react_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_GO: begin
        if (p1_e && p2_e) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLD;
          done_d  = 1'b1;
        end else if (p1_e || p2_e) begin
          rms_d  = react_q;
          done_d = 1'b1;
          cnt_d  = HOLD;
          if (p1_e) begin
            p1_d     = p1_inc;
            evt_d[0] = 1'b1;
          end else begin
            p2_d     = p2_inc;
            evt_d[1] = 1'b1;
          end
          if (p1_e && p1_inc == WIN) begin
            state_d = ST_MATCH_OVER;
            win_d   = WIN_P1;
          end else if (p2_e && p2_inc == WIN) begin
            state_d = ST_MATCH_OVER;
            win_d   = WIN_P2;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end else if (tick) begin
          react_d = (react_q == 16'hFFFF) ? react_q : react_q + 16'd1;
          if (32'(react_q) + 32'd1 >= 32'(TIMEOUT_MS)) begin
            state_d = ST_HOLDOFF;
            cnt_d   = HOLD;
            done_d  = 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_MATCH_OVER: ;
      default: state_d = ST_IDLE;
    endcase
    if (clear_scores) begin
      state_d = ST_IDLE;
      p1_d    = '0;
      p2_d    = '0;
      win_d   = WIN_NONE;
      evt_d   = 2'b00;
      done_d  = 1'b0;
    end
  end

  // State, LFSR, edge-detect history and output registers.
  always_ff @(posedge cin or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      p1_prev_q <= 1'b0;
      p2_prev_q <= 1'b0;
      cnt_q     <= '0;
      react_q   <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      evt_q     <= 2'b00;
      win_q     <= WIN_NONE;
      rms_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_next(lfsr_q);
      p1_prev_q <= p1_sw;
      p2_prev_q <= p2_sw;
      cnt_q     <= cnt_d;
      react_q   <= react_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      evt_q     <= evt_d;
      win_q     <= win_d;
      rms_q     <= rms_d;
      done_q    <= done_d;
    end
  end

  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign armed       = (state_q == ST_COUNTDOWN) || (state_q == ST_GO);
  assign go          = (state_q == ST_GO);
  assign score_evt   = evt_q;
  assign winner      = win_q;
  assign reaction_ms = rms_q;
  assign round_done  = done_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench: stimulus pushes expected round results, a monitor checks them on round_done.
module tb_reaction_round_ctrl;

  logic        cin, reset, start, clear_scores, p1_sw, p2_sw;
  logic [3:0]  p1_score, p2_score;
  logic        armed, go, round_done;
  logic [1:0]  score_evt, winner;
  logic [15:0] reaction_ms;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  p1;
    logic [3:0]  p2;
    logic [1:0]  evt;
    logic [1:0]  win;
    logic [15:0] rms;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  reaction_round_ctrl #(
    .TICK_DIV(4), .DELAY_MIN_MS(3), .DELAY_BITS(0), .TIMEOUT_MS(5),
    .HOLDOFF_MS(2), .WIN_SCORE(3), .SCORE_W(4)
  ) dut (
    .cin(cin), .reset(reset), .start(start), .clear_scores(clear_scores),
    .p1_sw(p1_sw), .p2_sw(p2_sw), .p1_score(p1_score), .p2_score(p2_score),
    .armed(armed), .go(go), .score_evt(score_evt), .winner(winner),
    .reaction_ms(reaction_ms), .round_done(round_done)
  );

  initial cin = 1'b0;
  always #5 cin = ~cin;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge cin);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic press(input logic b1, input logic b2, input int k);
    cyc(k);
    p1_sw = b1;
    p2_sw = b2;
    cyc(1);
    p1_sw = 1'b0;
    p2_sw = 1'b0;
  endtask

  task automatic expect_round(input logic [3:0] p1, input logic [3:0] p2,
                              input logic [1:0] evt, input logic [1:0] win,
                              input logic [15:0] rms);
    exp_t e;
    e.p1 = p1; e.p2 = p2; e.evt = evt; e.win = win; e.rms = rms;
    sb.push_back(e);
  endtask

  // Waits (bounded) for go after an accepted start; reports cycles and armed drops.
  task automatic wait_go(input string nm);
    int lat;
    int drop;
    lat  = 0;
    drop = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      lat++;
      if (!armed) drop++;
      if (go) break;
    end
    chk({nm, "_go_latency"}, lat, 12);
    chk({nm, "_armed_held"}, drop, 0);
  endtask

  // Monitor: every round_done pops one expectation; score_evt must never pulse alone.
  always @(negedge cin) begin
    if (reset) begin
      if (round_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_round_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_p1_score", p1_score, mon_e.p1);
          chk("sb_p2_score", p2_score, mon_e.p2);
          chk("sb_score_evt", score_evt, mon_e.evt);
          chk("sb_winner", winner, mon_e.win);
          chk("sb_reaction_ms", reaction_ms, mon_e.rms);
        end
      end else if (score_evt != 2'b00) begin
        chk("evt_without_round_done", score_evt, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; clear_scores = 1'b0; p1_sw = 1'b0; p2_sw = 1'b0;
    cyc(3);
    chk("rst_p1", p1_score, 0);
    chk("rst_p2", p2_score, 0);
    chk("rst_armed", armed, 0);
    chk("rst_go", go, 0);
    chk("rst_evt", score_evt, 0);
    chk("rst_winner", winner, 0);
    chk("rst_rms", reaction_ms, 0);
    chk("rst_done", round_done, 0);
    reset = 1'b1;
    cyc(2);

    // Round A: p1 wins 9 cycles into GO (2 ticks), then exact holdoff length.
    pulse_start();
    chk("A_armed_next", armed, 1);
    chk("A_go_low", go, 0);
    wait_go("A");
    expect_round(1, 0, 2'b01, 2'b00, 2);
    press(1, 0, 8);
    cyc(1);
    chk("A_evt_one_cycle", score_evt, 0);
    chk("A_p1_score", p1_score, 1);
    cyc(6);
    pulse_start();
    chk("A_holdoff_ignores_start", armed, 0);
    pulse_start();
    chk("A_idle_after_holdoff", armed, 1);

    // Round B: p2 wins at 5 cycles into GO (1 tick).
    wait_go("B");
    expect_round(1, 1, 2'b10, 2'b00, 1);
    press(0, 1, 4);
    cyc(8);

    // Round C: p2 false start with score 1 -> 0.
    pulse_start();
    expect_round(1, 0, 2'b10, 2'b00, 1);
    press(0, 1, 5);
    cyc(8);

    // Round D: p2 false start at score 0 -> no change, no event.
    pulse_start();
    expect_round(1, 0, 2'b00, 2'b00, 1);
    press(0, 1, 5);
    cyc(8);

    // Round E: simultaneous press in GO is a tie.
    pulse_start();
    wait_go("E");
    expect_round(1, 0, 2'b00, 2'b00, 1);
    press(1, 1, 3);
    cyc(8);

    // Start with a switch held is refused.
    p1_sw = 1'b1;
    cyc(2);
    pulse_start();
    chk("held_sw_start_refused", armed, 0);
    cyc(3);
    chk("held_sw_still_idle", armed, 0);
    p1_sw = 1'b0;
    cyc(2);

    // Timeout: no press for 5 ticks = 20 cycles.
    pulse_start();
    wait_go("T");
    expect_round(1, 0, 2'b00, 2'b00, 1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      n++;
      if (!go) break;
    end
    chk("timeout_len", n, 20);
    cyc(8);

    // p1 takes the match.
    pulse_start();
    wait_go("F");
    expect_round(2, 0, 2'b01, 2'b00, 0);
    press(1, 0, 2);
    cyc(8);
    pulse_start();
    wait_go("G");
    expect_round(3, 0, 2'b01, 2'b01, 3);
    press(1, 0, 12);
    cyc(8);
    chk("match_winner", winner, 1);
    pulse_start();
    chk("match_ignores_start", armed, 0);
    press(1, 0, 2);
    cyc(20);
    chk("match_p1_frozen", p1_score, 3);
    chk("match_winner_frozen", winner, 1);

    // clear_scores returns to IDLE with zeroed scores.
    clear_scores = 1'b1;
    cyc(1);
    clear_scores = 1'b0;
    chk("clr_p1", p1_score, 0);
    chk("clr_p2", p2_score, 0);
    chk("clr_winner", winner, 0);
    pulse_start();
    chk("clr_idle_start", armed, 1);
    wait_go("H");
    expect_round(0, 1, 2'b10, 2'b00, 2);
    press(0, 1, 8);
    cyc(8);

    // Asynchronous reset in COUNTDOWN, checked before any further clock edge.
    pulse_start();
    cyc(3);
    #2 reset = 1'b0;
    #1;
    chk("arst_armed", armed, 0);
    chk("arst_go", go, 0);
    chk("arst_p2", p2_score, 0);
    chk("arst_rms", reaction_ms, 0);
    chk("arst_winner", winner, 0);
    chk("arst_evt", score_evt, 0);
    chk("arst_done", round_done, 0);
    cyc(2);
    reset = 1'b1;
    cyc(3);
    chk("arst_stays_idle", armed, 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
